// File: rtl/dma_pkg.sv
// Shared opcodes, DMA state encoding and fixed addresses for the DMA demo system.
package dma_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [7:0] IO_PORT_ADDR = 8'h00;

  typedef enum logic [1:0] {IDLE, REQ, ACK} dma_state_e;

  // The CPU leaves the bus free on NOP and on the reserved opcode.
  function automatic logic cpu_bus_free(input logic [1:0] op);
    return (op == OP_NOP) || (op == OP_RSVD);
  endfunction
endpackage

// File: rtl/dma_controller.sv
// DMA FSM: waits for an I/O word, requests the bus, writes on grant, then acks the source.
module dma_controller
  import dma_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic io_req_i,
  input  logic bus_gnt_i,
  output logic bus_req_o,
  output logic dma_we_o,
  output logic io_ack_o
);

  dma_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus_req_o = 1'b0;
    dma_we_o  = 1'b0;
    io_ack_o  = 1'b0;
    unique case (state_q)
      IDLE: if (io_req_i) state_d = REQ;
      REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          dma_we_o = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        io_ack_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/dma_system.sv
// Single-register CPU, 256x32 memory, periodic I/O source and a cycle-stealing DMA.
module dma_system
  import dma_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 8,
  parameter int          IO_PERIOD = 8,
  parameter logic [31:0] IO_SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        opcode,
  input  logic [ADDR_W-1:0] input_address,
  output logic [DATA_W-1:0] cpu_register
);

  localparam int MEM_D = 2 ** ADDR_W;
  localparam int CNT_W = (IO_PERIOD > 1) ? $clog2(IO_PERIOD) : 1;
  localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_PORT_ADDR);

  logic [DATA_W-1:0] mem_q [MEM_D];
  logic [DATA_W-1:0] cpu_q, cpu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              io_req_q, io_req_d;
  logic              bus_req, bus_gnt, dma_we, io_ack;

  // CPU has absolute priority; DMA only gets cycles the CPU leaves idle.
  assign bus_gnt = bus_req & cpu_bus_free(opcode);

  dma_controller u_dma (
    .clk       (clk),
    .rst_n     (reset),
    .io_req_i  (io_req_q),
    .bus_gnt_i (bus_gnt),
    .bus_req_o (bus_req),
    .dma_we_o  (dma_we),
    .io_ack_o  (io_ack)
  );

  always_comb begin
    cpu_d = cpu_q;
    if (opcode == OP_LOAD) cpu_d = mem_q[input_address];
  end

  // Counter freezes while a word is pending so no word is ever lost.
  always_comb begin
    cnt_d    = cnt_q;
    word_d   = word_q;
    io_req_d = io_req_q;
    if (io_ack) begin
      io_req_d = 1'b0;
      word_d   = word_q + 1'b1;
      cnt_d    = '0;
    end else if (!io_req_q) begin
      if (cnt_q == CNT_W'(IO_PERIOD - 1)) io_req_d = 1'b1;
      else                                cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_q    <= '0;
      cnt_q    <= '0;
      word_q   <= DATA_W'(IO_SEED);
      io_req_q <= 1'b0;
    end else begin
      cpu_q    <= cpu_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      io_req_q <= io_req_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_D; i++) mem_q[i] <= '0;
    end else if (opcode == OP_STORE) begin
      mem_q[input_address] <= cpu_q;
    end else if (dma_we) begin
      mem_q[IO_ADDR] <= word_q;
    end
  end

  assign cpu_register = cpu_q;

endmodule

// File: tb/tb_dma_system.sv
// Directed bench for dma_system; expected values are hand-derived cycle by cycle.
module tb_dma_system;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  opcode;
  logic [7:0]  input_address;
  logic [31:0] cpu_register;

  int checks = 0;
  int errors = 0;

  dma_system dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .input_address (input_address),
    .cpu_register  (cpu_register)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (cpu_register === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, cpu_register, exp);
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [7:0] addr);
    opcode        = op;
    input_address = addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    opcode        = OP_NOP;
    input_address = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cpu", 32'h0);
    reset = 1'b1;

    step(OP_LOAD, 8'h05);
    check("load_after_reset", 32'h0);

    // First word reaches mem[0] on edge 10 after release.
    repeat (11) step(OP_NOP, 8'h00);
    step(OP_LOAD, 8'h00);
    check("first_io_word", 32'h1);

    step(OP_STORE, 8'h01);
    repeat (12) step(OP_NOP, 8'h00);
    step(OP_LOAD, 8'h00);
    check("second_io_word", 32'h2);
    step(OP_STORE, 8'h02);
    step(OP_LOAD, 8'h01);
    check("load_mem1", 32'h1);
    step(OP_LOAD, 8'h02);
    check("load_mem2", 32'h2);

    // Continuous LOADs starve the DMA.
    repeat (24) step(OP_LOAD, 8'h03);
    check("load_mem3", 32'h0);
    step(OP_LOAD, 8'h00);
    check("starved_io_port", 32'h2);
    step(OP_NOP, 8'h00);
    step(OP_LOAD, 8'h00);
    check("after_starve_word", 32'h3);

    // CPU store to the I/O port, later overwritten by the DMA.
    step(OP_LOAD, 8'h02);
    check("reload_mem2", 32'h2);
    step(OP_STORE, 8'h00);
    step(OP_LOAD, 8'h01);
    check("reload_mem1", 32'h1);
    step(OP_LOAD, 8'h00);
    check("cpu_store_io", 32'h2);
    repeat (8) step(OP_NOP, 8'h00);
    step(OP_LOAD, 8'h00);
    check("dma_overwrite", 32'h4);

    // Park the DMA in REQ, then reset mid-transfer.
    repeat (8) step(OP_LOAD, 8'h03);
    step(OP_LOAD, 8'h01);
    check("pre_reset_cpu", 32'h1);
    reset = 1'b0;
    #1;
    check("async_reset_cpu", 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    step(OP_LOAD, 8'h00);
    check("io_port_cleared", 32'h0);
    step(OP_LOAD, 8'h01);
    check("mem1_cleared", 32'h0);
    repeat (11) step(OP_RSVD, 8'h00);
    check("rsvd_keeps_zero", 32'h0);
    step(OP_LOAD, 8'h00);
    check("seed_after_reset", 32'h1);
    repeat (3) step(OP_RSVD, 8'h01);
    check("rsvd_keeps_value", 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
